// File: rtl/rf_pkg.sv
// Shared definitions for the register-file writeback path.
//   DATA_W   : result / register width
//   REG_AW   : register address width
//   NUM_REGS : number of architectural registers (register 0 is hardwired)
//   wb_req_t : one pending register write {dest, data}
//   wb_src_e : which source drives the writeback register this cycle
package rf_pkg;

    localparam int DATA_W   = 28;
    localparam int REG_AW   = 4;
    localparam int NUM_REGS = 2 ** REG_AW;

    typedef struct packed {
        logic [REG_AW-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_MEM
    } wb_src_e;

    // Register 0 is never written; any result aimed at it is silently dropped.
    function automatic logic dest_is_reg(input logic [REG_AW-1:0] d);
        return d != '0;
    endfunction

endpackage

// File: rtl/wb_sync_fifo.sv
// Small synchronous FIFO holding memory results until the writeback port is free.
//   clk, rst   : clock, asynchronous active-high reset (pointers/count only)
//   push       : write push_data (ignored when full)
//   push_data  : entry to store
//   pop        : discard the head entry (ignored when empty)
//   head_data  : current head entry, valid whenever empty is low
//   count      : number of stored entries, 0..DEPTH
//   full/empty : status flags derived from count
// Push and pop in the same cycle are both honoured and leave count unchanged.
module wb_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign count   = count_reg;

    // The arbiter must see the head in the same cycle it decides to pop,
    // so the head is read straight out of the storage array.
    assign head_data = mem_reg[rd_ptr_reg];

    // Storage is never reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/rf_writeback_arb.sv
// Writeback arbiter in front of the register file's single write port.
//   clk, rst              : clock, asynchronous active-high reset
//   alu_valid/ready/dest/data : ALU result handshake (1-cycle latency to wb_*)
//   mem_valid/ready/dest/data : memory result handshake, always via the FIFO
//   sb_set, sb_dest       : mark a register as waiting for a load
//   sb_pending            : per-register load-outstanding bits
//   sb_err                : sticky, a load was issued to an already-pending register
//   wb_wen/dest/data      : registered RF write port
//   rs0/rs1, rf_dout0/1   : RF read address / data
//   fwd_dout0/1           : read data with the in-flight writeback forwarded
// The ALU normally wins the port; after STARVE_MAX consecutive ALU wins while
// memory results are waiting, the ALU is held off for one cycle so the FIFO drains.
module rf_writeback_arb
    import rf_pkg::*;
#(
    parameter int MFIFO_DEPTH = 4,
    parameter int STARVE_MAX  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [REG_AW-1:0]   alu_dest,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [REG_AW-1:0]   mem_dest,
    input  logic [DATA_W-1:0]   mem_data,
    input  logic                sb_set,
    input  logic [REG_AW-1:0]   sb_dest,
    output logic [NUM_REGS-1:0] sb_pending,
    output logic                sb_err,
    output logic                wb_wen,
    output logic [REG_AW-1:0]   wb_dest,
    output logic [DATA_W-1:0]   wb_data,
    input  logic [REG_AW-1:0]   rs0,
    input  logic [REG_AW-1:0]   rs1,
    input  logic [DATA_W-1:0]   rf_dout0,
    input  logic [DATA_W-1:0]   rf_dout1,
    output logic [DATA_W-1:0]   fwd_dout0,
    output logic [DATA_W-1:0]   fwd_dout1
);

    localparam int FCW = $clog2(MFIFO_DEPTH) + 1;
    localparam int SCW = $clog2(STARVE_MAX + 1);
    localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);

    // ------------------------------------------------------------------
    // Memory-result FIFO
    // ------------------------------------------------------------------
    wb_req_t        mem_req;
    wb_req_t        fifo_head;
    logic [FCW-1:0] fifo_count;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_push;
    logic           fifo_pop;

    assign mem_req.dest = mem_dest;
    assign mem_req.data = mem_data;

    // Held low during reset so nothing is accepted into a FIFO being cleared.
    assign mem_ready = ~rst & (fifo_count < FCW'(MFIFO_DEPTH));
    assign fifo_push = mem_valid & mem_ready & ~fifo_full;

    wb_sync_fifo #(
        .DEPTH (MFIFO_DEPTH),
        .WIDTH ($bits(wb_req_t))
    ) u_mem_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (mem_req),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [SCW-1:0] starve_reg;
    logic [SCW-1:0] starve_next;
    wb_src_e        wb_src;

    assign alu_ready = (starve_reg != STARVE_LIM);

    always_comb begin
        wb_src = WB_NONE;
        if (alu_valid && alu_ready) begin
            wb_src = WB_ALU;
        end else if (!fifo_empty) begin
            wb_src = WB_MEM;
        end
    end

    assign fifo_pop = (wb_src == WB_MEM);

    // Counts ALU wins that happened while memory results were waiting.
    // Once it hits the limit alu_ready drops, the FIFO necessarily wins,
    // and the pop clears the count again.
    always_comb begin
        starve_next = starve_reg;
        if (fifo_pop || fifo_empty) begin
            starve_next = '0;
        end else if ((wb_src == WB_ALU) && (starve_reg != STARVE_LIM)) begin
            starve_next = starve_reg + SCW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_reg <= '0;
        end else begin
            starve_reg <= starve_next;
        end
    end

    // ------------------------------------------------------------------
    // Writeback register
    // ------------------------------------------------------------------
    logic              wb_wen_reg;
    logic              wb_wen_next;
    logic [REG_AW-1:0] wb_dest_reg;
    logic [REG_AW-1:0] wb_dest_next;
    logic [DATA_W-1:0] wb_data_reg;
    logic [DATA_W-1:0] wb_data_next;

    // Results aimed at register 0 are consumed like any other but leave
    // the write port idle, so dest/data simply hold.
    always_comb begin
        wb_wen_next  = 1'b0;
        wb_dest_next = wb_dest_reg;
        wb_data_next = wb_data_reg;
        case (wb_src)
            WB_ALU: begin
                if (dest_is_reg(alu_dest)) begin
                    wb_wen_next  = 1'b1;
                    wb_dest_next = alu_dest;
                    wb_data_next = alu_data;
                end
            end
            WB_MEM: begin
                if (dest_is_reg(fifo_head.dest)) begin
                    wb_wen_next  = 1'b1;
                    wb_dest_next = fifo_head.dest;
                    wb_data_next = fifo_head.data;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_wen_reg  <= 1'b0;
            wb_dest_reg <= '0;
            wb_data_reg <= '0;
        end else begin
            wb_wen_reg  <= wb_wen_next;
            wb_dest_reg <= wb_dest_next;
            wb_data_reg <= wb_data_next;
        end
    end

    assign wb_wen  = wb_wen_reg;
    assign wb_dest = wb_dest_reg;
    assign wb_data = wb_data_reg;

    // ------------------------------------------------------------------
    // Load scoreboard
    // ------------------------------------------------------------------
    // The bit clears on the pop cycle, one cycle before the RF write lands;
    // forwarding from wb_* covers that gap for readers.
    assign sb_pending[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_sb
            logic pend_reg;
            logic pend_next;
            logic set_hit;
            logic clr_hit;

            assign set_hit = sb_set & (sb_dest == REG_AW'(gi));
            assign clr_hit = fifo_pop & (fifo_head.dest == REG_AW'(gi));
            // A new load to the same register outranks the retiring one.
            assign pend_next = set_hit | (pend_reg & ~clr_hit);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pend_reg <= 1'b0;
                end else begin
                    pend_reg <= pend_next;
                end
            end

            assign sb_pending[gi] = pend_reg;
        end
    endgenerate

    logic sb_err_reg;
    logic sb_err_next;

    assign sb_err_next = sb_err_reg
                       | (sb_set & dest_is_reg(sb_dest) & sb_pending[sb_dest]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_err_reg <= 1'b0;
        end else begin
            sb_err_reg <= sb_err_next;
        end
    end

    assign sb_err = sb_err_reg;

    // ------------------------------------------------------------------
    // Operand forwarding
    // ------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [DATA_W-1:0] rf_dout
    );
        if (wb_wen_reg && (wb_dest_reg == rs) && dest_is_reg(rs)) begin
            return wb_data_reg;
        end
        return rf_dout;
    endfunction

    assign fwd_dout0 = fwd_sel(rs0, rf_dout0);
    assign fwd_dout1 = fwd_sel(rs1, rf_dout1);

endmodule

// File: tb/tb_rf_writeback_arb.sv
// Scoreboard bench for rf_writeback_arb: stimulus pushes the expected RF
// writes into a queue in hand-computed order; a monitor pops and compares
// every cycle the DUT asserts wb_wen. Status outputs are checked inline.
module tb_rf_writeback_arb;
    import rf_pkg::*;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                alu_valid = 1'b0;
    logic                alu_ready;
    logic [REG_AW-1:0]   alu_dest = '0;
    logic [DATA_W-1:0]   alu_data = '0;
    logic                mem_valid = 1'b0;
    logic                mem_ready;
    logic [REG_AW-1:0]   mem_dest = '0;
    logic [DATA_W-1:0]   mem_data = '0;
    logic                sb_set = 1'b0;
    logic [REG_AW-1:0]   sb_dest = '0;
    logic [NUM_REGS-1:0] sb_pending;
    logic                sb_err;
    logic                wb_wen;
    logic [REG_AW-1:0]   wb_dest;
    logic [DATA_W-1:0]   wb_data;
    logic [REG_AW-1:0]   rs0 = '0;
    logic [REG_AW-1:0]   rs1 = '0;
    logic [DATA_W-1:0]   rf_dout0 = '0;
    logic [DATA_W-1:0]   rf_dout1 = '0;
    logic [DATA_W-1:0]   fwd_dout0;
    logic [DATA_W-1:0]   fwd_dout1;

    int errors = 0;
    int checks = 0;
    wb_req_t exp_q[$];

    always #5 clk = ~clk;

    rf_writeback_arb #(
        .MFIFO_DEPTH (4),
        .STARVE_MAX  (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_dest   (alu_dest),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_dest   (mem_dest),
        .mem_data   (mem_data),
        .sb_set     (sb_set),
        .sb_dest    (sb_dest),
        .sb_pending (sb_pending),
        .sb_err     (sb_err),
        .wb_wen     (wb_wen),
        .wb_dest    (wb_dest),
        .wb_data    (wb_data),
        .rs0        (rs0),
        .rs1        (rs1),
        .rf_dout0   (rf_dout0),
        .rf_dout1   (rf_dout1),
        .fwd_dout0  (fwd_dout0),
        .fwd_dout1  (fwd_dout1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wb(input logic [REG_AW-1:0] d, input logic [DATA_W-1:0] v);
        wb_req_t e;
        e.dest = d;
        e.data = v;
        exp_q.push_back(e);
    endtask

    // Monitor: every RF write must match the next expected entry.
    always @(negedge clk) begin
        wb_req_t e;
        if (wb_wen === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got dest=%0d data=0x%0h required no write",
                         wb_dest, wb_data);
            end else begin
                e = exp_q.pop_front();
                if (wb_dest !== e.dest || wb_data !== e.data) begin
                    errors++;
                    $display("FAIL wb_write: got dest=%0d data=0x%0h required dest=%0d data=0x%0h",
                             wb_dest, wb_data, e.dest, e.data);
                end else begin
                    $display("wb write dest=%0d data=0x%0h", wb_dest, wb_data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit rdy_tbl [17] = '{1,1,1,1,0,1,1,1,0,1,1,1,0,1,1,1,0};
        bit mrdy_tbl [6] = '{1,1,1,1,0,1};
        wb_req_t mem_tbl [4];
        int ai;
        int mi;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wb_wen", wb_wen, 0);
        chk("rst_wb_dest", wb_dest, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_sb_pending", sb_pending, 0);
        chk("rst_sb_err", sb_err, 0);
        chk("rst_alu_ready", alu_ready, 1);
        chk("rst_mem_ready", mem_ready, 0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_mem_ready", mem_ready, 1);

        // ---------------- ALU only ----------------
        next_cycle();
        alu_valid = 1'b1; alu_dest = 4'd3; alu_data = 28'h0001234;
        expect_wb(4'd3, 28'h0001234);
        @(negedge clk);
        chk("alu_ready", alu_ready, 1);
        next_cycle();
        alu_valid = 1'b0;
        @(negedge clk);
        chk("alu_lat1_wen", wb_wen, 1);
        chk("alu_lat1_dest", wb_dest, 3);

        // ---------------- memory only ----------------
        next_cycle();
        sb_set = 1'b1; sb_dest = 4'd5;
        next_cycle();
        sb_set = 1'b0;
        mem_valid = 1'b1; mem_dest = 4'd5; mem_data = 28'hABCDEF0;
        expect_wb(4'd5, 28'hABCDEF0);
        @(negedge clk);
        chk("sb_pend5_set", sb_pending[5], 1);
        next_cycle();
        mem_valid = 1'b0;
        @(negedge clk);
        chk("mem_lat_n1_wen", wb_wen, 0);
        chk("sb_pend5_wait", sb_pending[5], 1);
        next_cycle();
        @(negedge clk);
        chk("mem_lat2_wen", wb_wen, 1);
        chk("sb_pend5_clr", sb_pending[5], 0);
        next_cycle();
        @(negedge clk);
        chk("idle_wen", wb_wen, 0);
        chk("idle_dest_hold", wb_dest, 5);

        // ---------------- contention ----------------
        for (int i = 0; i < 4; i++) begin
            mem_tbl[i].dest = REG_AW'(9 + i);
            mem_tbl[i].data = 28'h0B00000 + DATA_W'(i);
        end
        ai = 0;
        mi = 0;
        for (int c = 0; c < 17; c++) begin
            next_cycle();
            alu_valid = 1'b1;
            alu_dest  = REG_AW'(1 + (ai % 13));
            alu_data  = 28'h0A00000 + DATA_W'(ai);
            mem_valid = (c < 4);
            if (c < 4) begin
                mem_dest = mem_tbl[c].dest;
                mem_data = mem_tbl[c].data;
            end
            if (rdy_tbl[c]) begin
                expect_wb(alu_dest, alu_data);
                ai++;
            end else begin
                expect_wb(mem_tbl[mi].dest, mem_tbl[mi].data);
                mi++;
            end
            @(negedge clk);
            chk($sformatf("starve_alu_ready_c%0d", c), alu_ready, 32'(rdy_tbl[c]));
            if (c < 6) begin
                chk($sformatf("mem_ready_c%0d", c), mem_ready, 32'(mrdy_tbl[c]));
            end
        end
        next_cycle();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        repeat (2) next_cycle();

        // ---------------- register 0 ----------------
        alu_valid = 1'b1; alu_dest = 4'd0; alu_data = 28'hDEAD000;
        @(negedge clk);
        chk("r0_alu_ready", alu_ready, 1);
        next_cycle();
        alu_valid = 1'b0;
        mem_valid = 1'b1; mem_dest = 4'd0; mem_data = 28'h0C0FFEE;
        @(negedge clk);
        chk("r0_alu_no_wen", wb_wen, 0);
        next_cycle();
        mem_valid = 1'b1; mem_dest = 4'd6; mem_data = 28'h0060606;
        expect_wb(4'd6, 28'h0060606);
        @(negedge clk);
        chk("r0_wait_wen", wb_wen, 0);
        next_cycle();
        mem_valid = 1'b0;
        @(negedge clk);
        chk("r0_mem_no_wen", wb_wen, 0);
        next_cycle();
        rs0 = 4'd0; rf_dout0 = 28'h1111111;
        rs1 = 4'd6; rf_dout1 = 28'h2222222;
        @(negedge clk);
        chk("r0_then_r6_wen", wb_wen, 1);
        chk("fwd_rs0_zero", fwd_dout0, 28'h1111111);
        chk("fwd_rs1_r6", fwd_dout1, 28'h0060606);

        // ---------------- forwarding ----------------
        next_cycle();
        alu_valid = 1'b1; alu_dest = 4'd7; alu_data = 28'h0000055;
        expect_wb(4'd7, 28'h0000055);
        next_cycle();
        alu_valid = 1'b0;
        rs0 = 4'd7; rf_dout0 = 28'h0000000;
        rs1 = 4'd8; rf_dout1 = 28'h2222222;
        @(negedge clk);
        chk("fwd_hit_dout0", fwd_dout0, 28'h0000055);
        chk("fwd_miss_dout1", fwd_dout1, 28'h2222222);
        next_cycle();
        rf_dout0 = 28'h3333333;
        @(negedge clk);
        chk("fwd_idle_dout0", fwd_dout0, 28'h3333333);

        // ---------------- scoreboard error and reset ----------------
        next_cycle();
        sb_set = 1'b1; sb_dest = 4'd2;
        next_cycle();
        @(negedge clk);
        chk("sb_first_no_err", sb_err, 0);
        chk("sb_pend2", sb_pending[2], 1);
        next_cycle();
        sb_set = 1'b0;
        @(negedge clk);
        chk("sb_double_err", sb_err, 1);
        chk("sb_pend2_stays", sb_pending[2], 1);
        next_cycle();
        alu_valid = 1'b1; alu_dest = 4'd0; alu_data = 28'h0000001;
        mem_valid = 1'b1; mem_dest = 4'd10; mem_data = 28'h0AAAAAA;
        next_cycle();
        mem_dest = 4'd11; mem_data = 28'h0BBBBBB;
        @(negedge clk);
        chk("fill_alu_ready", alu_ready, 1);
        next_cycle();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_wb_wen", wb_wen, 0);
        chk("arst_wb_dest", wb_dest, 0);
        chk("arst_wb_data", wb_data, 0);
        chk("arst_sb_err", sb_err, 0);
        chk("arst_sb_pending", sb_pending, 0);
        chk("arst_mem_ready", mem_ready, 0);
        chk("arst_alu_ready", alu_ready, 1);
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("post_arst_no_wen_%0d", k), wb_wen, 0);
            next_cycle();
        end
        alu_valid = 1'b1; alu_dest = 4'd1; alu_data = 28'h0000777;
        expect_wb(4'd1, 28'h0000777);
        next_cycle();
        alu_valid = 1'b0;
        @(negedge clk);
        chk("resume_wen", wb_wen, 1);
        repeat (2) next_cycle();
        chk("exp_q_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
